// File: rtl/chip8_mem_responder.sv
// CHIP-8 memory responder: 4 KiB byte RAM answering byte writes and big-endian 16-bit fetches.
// Optional CHIP8_FONT_ROM_EN overlays the read-only hex font on 0x000-0x04F.
module chip8_mem_responder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [11:0] addr,
    input  logic [7:0]  wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle,
        StFetchHi,
        StFetchLo,
        StResp,
        StWrite
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  hi_q;
    logic [15:0] rdata_q;
    logic [11:0] rd_addr;
    logic [7:0]  rd_byte;
    logic        mem_we;
    logic        rom_hit_wr;

    logic [7:0]  mem [4096];

`ifdef CHIP8_FONT_ROM_EN
    localparam logic [7:0] FontRom [80] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    assign rom_hit_wr = (addr_q < 12'h050);
    assign rd_byte    = (rd_addr < 12'h050) ? FontRom[rd_addr[6:0]] : mem[rd_addr];
`else
    assign rom_hit_wr = 1'b0;
    assign rd_byte    = mem[rd_addr];
`endif

    // The low byte address wraps naturally at 12 bits (0xFFF + 1 -> 0x000).
    assign rd_addr = (state_q == StFetchLo) ? addr_q + 12'd1 : addr_q;
    assign mem_we  = (state_q == StWrite) && !rom_hit_wr;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (req) state_d = we ? StWrite : StFetchHi;
            StFetchHi: state_d = StFetchLo;
            StFetchLo: state_d = StResp;
            StResp:    state_d = StIdle;
            StWrite:   state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= 12'h000;
            wdata_q <= 8'h00;
            hi_q    <= 8'h00;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req) begin
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state_q == StFetchHi) hi_q <= rd_byte;
            // Word becomes visible as the FSM enters RESP, so it is valid with ack.
            if (state_q == StFetchLo) rdata_q <= {hi_q, rd_byte};
        end
    end

    // Storage has no reset; an async reset drops WRITE before its edge, so no commit.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= wdata_q;
    end

    always_comb begin
        err = 1'b0;
        if (state_q == StResp)  err = addr_q[0];
        if (state_q == StWrite) err = rom_hit_wr;
    end

    assign ack   = (state_q == StResp) || (state_q == StWrite);
    assign busy  = (state_q != StIdle);
    assign rdata = rdata_q;

endmodule
